// File: rtl/display_pkg.sv
// Shared constants for the two-digit 7-segment display driver.
// Segment patterns are active-low, written abcdefg (a is the leftmost bit).
package display_pkg;

  localparam int unsigned CNT_W_DEFAULT = 17;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_A     = 7'b0001000;
  localparam logic [0:6] SEG_B     = 7'b1100000;
  localparam logic [0:6] SEG_C     = 7'b0110001;
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_F     = 7'b0111000;

  localparam logic [1:0] ANODE_ONES = 2'b10;
  localparam logic [1:0] ANODE_TENS = 2'b01;
  localparam logic [1:0] ANODE_OFF  = 2'b11;

endpackage

// File: rtl/display_driver_seg7_encoder.sv
// Combinational digit-to-segment encoder (active-low abcdefg).
// Hex glyphs A..F are present only when DISPLAY_DRIVER_HEX_EN is defined.
module seg7_encoder
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [0:6] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:  seg_o = SEG_0;
      4'd1:  seg_o = SEG_1;
      4'd2:  seg_o = SEG_2;
      4'd3:  seg_o = SEG_3;
      4'd4:  seg_o = SEG_4;
      4'd5:  seg_o = SEG_5;
      4'd6:  seg_o = SEG_6;
      4'd7:  seg_o = SEG_7;
      4'd8:  seg_o = SEG_8;
      4'd9:  seg_o = SEG_9;
`ifdef DISPLAY_DRIVER_HEX_EN
      4'd10: seg_o = SEG_A;
      4'd11: seg_o = SEG_B;
      4'd12: seg_o = SEG_C;
      4'd13: seg_o = SEG_D;
      4'd14: seg_o = SEG_E;
      4'd15: seg_o = SEG_F;
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_driver.sv
// Two-digit multiplexed common-anode 7-segment driver showing a 5-bit switch value.
// Decimal by default; define DISPLAY_DRIVER_HEX_EN for hex digits.
module display_driver
  import display_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [4:0] switch,
  output logic [0:6] seg,
  output logic [1:0] anode
);

  logic [4:0]       sw_s1_q, sw_s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [0:6]       seg_q, seg_d;
  logic [1:0]       anode_q, anode_d;
  logic             sel;
  logic [3:0]       tens, ones, digit;
  logic [0:6]       enc_seg;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      cnt_q   <= '0;
      seg_q   <= SEG_BLANK;
      anode_q <= ANODE_OFF;
    end else begin
      sw_s1_q <= switch;
      sw_s2_q <= sw_s1_q;
      cnt_q   <= cnt_q + 1'b1;
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  assign sel = cnt_q[CNT_W-1];

`ifdef DISPLAY_DRIVER_HEX_EN
  always_comb begin
    tens = {3'b000, sw_s2_q[4]};
    ones = sw_s2_q[3:0];
  end
`else
  // Value is at most 31, so three compare/subtract steps give tens and ones.
  logic [4:0] rem;
  always_comb begin
    rem  = sw_s2_q;
    tens = 4'd0;
    if (sw_s2_q >= 5'd30) begin
      tens = 4'd3;
      rem  = sw_s2_q - 5'd30;
    end else if (sw_s2_q >= 5'd20) begin
      tens = 4'd2;
      rem  = sw_s2_q - 5'd20;
    end else if (sw_s2_q >= 5'd10) begin
      tens = 4'd1;
      rem  = sw_s2_q - 5'd10;
    end
    ones = rem[3:0];
  end
`endif

  assign digit = sel ? tens : ones;

  seg7_encoder u_enc (
    .digit_i (digit),
    .seg_o   (enc_seg)
  );

  always_comb begin
    anode_d = sel ? ANODE_TENS : ANODE_ONES;
    seg_d   = enc_seg;
  end

  assign seg   = seg_q;
  assign anode = anode_q;

endmodule

// File: tb/tb_display_driver.sv
// Randomized self-checking bench for display_driver (CNT_W=2 and CNT_W=1 instances).
// Expected outputs come from a cycle-indexed switch history and arithmetic digit split.
module tb_display_driver;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [4:0] switch = 5'd0;
  logic [0:6] seg2, seg1;
  logic [1:0] anode2, anode1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned k = 0;
  logic [4:0]  hist[$];
  logic [6:0]  enc_tab[16];

  always #50 clk_in = ~clk_in;

  display_driver #(.CNT_W(2)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .switch (switch),
    .seg    (seg2),
    .anode  (anode2)
  );

  display_driver #(.CNT_W(1)) dut1 (
    .clk_in (clk_in),
    .rst    (rst),
    .switch (switch),
    .seg    (seg1),
    .anode  (anode1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int unsigned d);
    return enc_tab[d];
  endfunction

  task automatic check_outputs();
    int unsigned v, tens, ones, sel2, sel1;
    v = (k >= 3) ? int'(hist[k-3]) : 0;
`ifdef DISPLAY_DRIVER_HEX_EN
    tens = v / 16;
    ones = v % 16;
`else
    tens = v / 10;
    ones = v % 10;
`endif
    sel2 = ((k - 1) / 2) % 2;
    sel1 = (k - 1) % 2;
    chk("anode_w2", {30'd0, anode2}, sel2 ? 32'b01 : 32'b10);
    chk("seg_w2",   {25'd0, seg2},   {25'd0, enc(sel2 ? tens : ones)});
    chk("anode_w1", {30'd0, anode1}, sel1 ? 32'b01 : 32'b10);
    chk("seg_w1",   {25'd0, seg1},   {25'd0, enc(sel1 ? tens : ones)});
  endtask

  task automatic check_blank(input string tag);
    chk({tag, "_seg_w2"},   {25'd0, seg2},   32'h7F);
    chk({tag, "_anode_w2"}, {30'd0, anode2}, 32'h3);
    chk({tag, "_seg_w1"},   {25'd0, seg1},   32'h7F);
    chk({tag, "_anode_w1"}, {30'd0, anode1}, 32'h3);
  endtask

  task automatic step(input bit rnd);
    @(posedge clk_in);
    hist.push_back(switch);
    k++;
    @(negedge clk_in);
    check_outputs();
    if (rnd && $urandom_range(2) == 0) switch = 5'($urandom_range(31));
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    rst = 1'b0;
    k = 0;
    hist.delete();
  endtask

  // Reset pulse landing between clock edges; outputs must blank before the next edge.
  task automatic async_reset();
    @(posedge clk_in);
    #20 rst = 1'b1;
    #1 check_blank("async_rst");
    release_reset();
  endtask

  initial begin
    enc_tab[0]  = 7'b0000001; enc_tab[1]  = 7'b1001111;
    enc_tab[2]  = 7'b0010010; enc_tab[3]  = 7'b0000110;
    enc_tab[4]  = 7'b1001100; enc_tab[5]  = 7'b0100100;
    enc_tab[6]  = 7'b0100000; enc_tab[7]  = 7'b0001111;
    enc_tab[8]  = 7'b0000000; enc_tab[9]  = 7'b0000100;
`ifdef DISPLAY_DRIVER_HEX_EN
    enc_tab[10] = 7'b0001000; enc_tab[11] = 7'b1100000;
    enc_tab[12] = 7'b0110001; enc_tab[13] = 7'b1000010;
    enc_tab[14] = 7'b0110000; enc_tab[15] = 7'b0111000;
`else
    for (int unsigned i = 10; i < 16; i++) enc_tab[i] = 7'b1111111;
`endif

    // Held reset: blank on every cycle even with a nonzero switch.
    switch = 5'd3;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check_blank("reset_held");
    end

    // "03" after release, then the top value.
    release_reset();
    for (int unsigned i = 0; i < 10; i++) step(1'b0);
    switch = 5'd31;
    for (int unsigned i = 0; i < 8; i++) step(1'b0);

    // Sweep every value, several phases each; 9->10 covers a tens rollover.
    for (int unsigned v = 0; v < 32; v++) begin
      switch = 5'(v);
      for (int unsigned i = 0; i < 6; i++) step(1'b0);
    end

    // Random switch activity with occasional mid-scan resets.
    for (int unsigned r = 0; r < 6; r++) begin
      async_reset();
      for (int unsigned i = 0; i < 60 + $urandom_range(40); i++) step(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_driver.md
Name: display_driver

Overview:
- Two-digit multiplexed 7-segment display driver for the board-level top.
- Takes a 5-bit switch value (0..31) and shows it as two decimal digits ("00".."31") on a common-anode display.
- Contains an input synchroniser, a refresh counter, a binary-to-BCD split, a segment encoder, and registered anode/segment outputs.

Parameters:
- CNT_W, default 17: refresh counter width. The digit select is counter bit CNT_W-1, so each digit is lit for 2^(CNT_W-1) clocks. Legal range is 1..24.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- switch  input  5  value to display; asynchronous to clk_in.
- seg  output  7 [0:6]  active-low segments. seg[0]=a, seg[1]=b, ..., seg[6]=g.
- anode  output  2  active-low digit enables. anode[0] is the ones (right) digit; anode[1] is the tens (left) digit.

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser regs = 0, refresh counter = 0.
  - seg = 7'b1111111 (blank), anode = 2'b11 (both digits off).
- Input sync: two-flop synchroniser sw_s1 -> sw_s2. The display uses sw_s2 only. switch-to-value latency is 2 clocks.
- Refresh counter: cnt increments by 1 every clock and wraps from 2^CNT_W-1 to 0 with no special handling. sel = cnt[CNT_W-1].
- Digit split (combinational from sw_s2): tens = sw_s2/10 (0..3), ones = sw_s2%10. Implement as compare/subtract; no divider primitive.
- Output register, updated every clock from the current cnt and sw_s2:
  - sel=0: anode <= 2'b10, seg <= enc(ones).
  - sel=1: anode <= 2'b01, seg <= enc(tens).
  - Exactly one anode is low at any time after the first post-reset clock.
- Leading zero: the tens digit 0 is displayed as "0". Value 3 shows "03".
- enc (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other code = 1111111 (blank).
- First clock after reset release: anode=2'b10, seg=enc(0) (the synchroniser is still 0). The true ones digit appears from the 3rd clock after release.
- Switch change mid-scan: the new value is taken on the next output update after it reaches sw_s2. No tearing protection between digits.
- Reset asserted mid-scan: outputs immediately go to blank/off; the counter restarts at 0.

Optional Feature:
- Macro DISPLAY_DRIVER_HEX_EN.
- Defined: digits are hex instead of decimal.
  - tens = sw_s2[4], ones = sw_s2[3:0]; 0x1F shows "1F".
  - Extra encodings: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Undefined: decimal behaviour as above. enc codes 10..15 blank.

Decomposition:
- Package display_pkg:
  - SEG_BLANK constant and the 16 segment-pattern constants.
  - ANODE_ONES=2'b10, ANODE_TENS=2'b01, ANODE_OFF=2'b11.
  - Default CNT_W.
- Sub-module seg7_encoder: 4-bit digit in, 7-bit active-low seg out, purely combinational. Hex entries are gated by DISPLAY_DRIVER_HEX_EN.
- BCD split and counter stay in the top.

Test Plan (CNT_W=2 unless stated, 100 ns clock):
- rst=1 held -> seg=1111111 and anode=11 continuously; assert rst asynchronously mid-cycle -> outputs blank within the same cycle.
- switch=5'b00011, release rst -> cycle 1: anode=10, seg=0000001; from cycle 3 on the ones phase: anode=10, seg=0000110; tens phase (anode=01): seg=0000001. Each phase lasts 2 clocks.
- switch=31 -> tens phase seg=0000110 (3), ones phase seg=1001111 (1).
- Sweep switch 0..31, checking both digits against /10 and %10; with DISPLAY_DRIVER_HEX_EN, switch=5'h1F -> tens=1001111, ones=0111000.
- CNT_W=1 -> anode alternates 10/01 every clock and is never 00 or 11 after reset; counter wrap keeps the alternation seamless.
- Change switch 9->10 mid-scan -> the new digits appear within 3 clocks (2 sync + 1 output); no illegal anode value at any point.
